// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and
// the request legality checks used when a new access is accepted.
package lsu_pkg;

    localparam int LSU_STATE_WIDTH = 2;

    typedef enum logic [LSU_STATE_WIDTH-1:0] {
        LSU_STATE_IDLE = 2'd0,
        LSU_STATE_REQ  = 2'd1,
        LSU_STATE_WAIT = 2'd2,
        LSU_STATE_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LSU_F3_LB  = 3'b000;
    localparam logic [2:0] LSU_F3_LH  = 3'b001;
    localparam logic [2:0] LSU_F3_LW  = 3'b010;
    localparam logic [2:0] LSU_F3_LBU = 3'b100;
    localparam logic [2:0] LSU_F3_LHU = 3'b101;
    localparam logic [2:0] LSU_F3_SB  = 3'b000;
    localparam logic [2:0] LSU_F3_SH  = 3'b001;
    localparam logic [2:0] LSU_F3_SW  = 3'b010;

    function automatic logic f3_illegal(input logic wen, input logic [2:0] funct3);
        if (wen)
            return !(funct3 inside {LSU_F3_SB, LSU_F3_SH, LSU_F3_SW});
        return !(funct3 inside {LSU_F3_LB, LSU_F3_LH, LSU_F3_LW, LSU_F3_LBU, LSU_F3_LHU});
    endfunction

    // Access size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-request, data-memory bus and writeback-response signals of the LSU.
// The LSU sits on the slave modport; the core/memory environment on master.
interface lsu_if;

    logic        io_req_valid;
    logic        io_req_ready;
    logic [31:0] io_req_addr;
    logic [31:0] io_req_wdata;
    logic        io_req_wen;
    logic [2:0]  io_req_funct3;

    logic        io_mem_valid;
    logic        io_mem_ready;
    logic [31:0] io_mem_addr;
    logic        io_mem_wen;
    logic [31:0] io_mem_wdata;
    logic [3:0]  io_mem_wstrb;
    logic        io_mem_rvalid;
    logic [31:0] io_mem_rdata;

    logic        io_resp_valid;
    logic [31:0] io_resp_rdata;
    logic        io_resp_misaligned;
    logic        io_resp_fault;

    modport slave (
        input  io_req_valid, io_req_addr, io_req_wdata, io_req_wen, io_req_funct3,
        input  io_mem_ready, io_mem_rvalid, io_mem_rdata,
        output io_req_ready,
        output io_mem_valid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wstrb,
        output io_resp_valid, io_resp_rdata, io_resp_misaligned, io_resp_fault
    );

    modport master (
        output io_req_valid, io_req_addr, io_req_wdata, io_req_wen, io_req_funct3,
        output io_mem_ready, io_mem_rvalid, io_mem_rdata,
        input  io_req_ready,
        input  io_mem_valid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wstrb,
        input  io_resp_valid, io_resp_rdata, io_resp_misaligned, io_resp_fault
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication and write strobes, plus load
// lane extraction with sign/zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        wen,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        mem_wdata = store_data;
        mem_wstrb = 4'b0000;
        load_data = 32'h0;
        shifted   = mem_rdata >> {offset, 3'b000};

        if (wen) begin
            case (funct3)
                LSU_F3_SB: begin
                    mem_wdata = {4{store_data[7:0]}};
                    mem_wstrb = 4'b0001 << offset;
                end
                LSU_F3_SH: begin
                    mem_wdata = {2{store_data[15:0]}};
                    mem_wstrb = 4'b0011 << offset;
                end
                default:   mem_wstrb = 4'b1111;
            endcase
        end

        case (funct3)
            LSU_F3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_F3_LBU: load_data = {24'h0, shifted[7:0]};
            LSU_F3_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            LSU_F3_LHU: load_data = {16'h0, shifted[15:0]};
            default:    load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one ALU-addressed access at a time, drives it on
// the valid/ready data bus with a response timeout and returns a 1-cycle result.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic clock,
    input  logic reset,
    lsu_if.slave bus
);

    lsu_state_e       state_q, state_d;
    logic [31:0]      addr_q, wdata_q;
    logic             wen_q;
    logic [2:0]       f3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rdata_q;
    logic             mis_q, fault_q;

    logic        req_illegal, req_mis;
    logic        timeout_hit, rsp_hit;
    logic [31:0] load_data;

    assign req_illegal = f3_illegal(bus.io_req_wen, bus.io_req_funct3);
    assign req_mis     = addr_misaligned(bus.io_req_funct3, bus.io_req_addr[1:0]);
    assign timeout_hit = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    assign rsp_hit     = (state_q == LSU_STATE_WAIT) && bus.io_mem_rvalid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) state_q <= LSU_STATE_IDLE;
        else       state_q <= state_d;
    end

    // The timeout counts REQ and WAIT together; a response landing on the
    // final cycle still takes priority over the abandon.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_STATE_IDLE:
                if (bus.io_req_valid)
                    state_d = (req_illegal || req_mis) ? LSU_STATE_RESP : LSU_STATE_REQ;
            LSU_STATE_REQ:
                if (timeout_hit)            state_d = LSU_STATE_RESP;
                else if (bus.io_mem_ready)  state_d = LSU_STATE_WAIT;
            LSU_STATE_WAIT:
                if (bus.io_mem_rvalid || timeout_hit) state_d = LSU_STATE_RESP;
            LSU_STATE_RESP:
                state_d = LSU_STATE_IDLE;
            default:
                state_d = LSU_STATE_IDLE;
        endcase
    end

    // NOTE: payload registers are reset as well as the state, because they
    // drive bus and response outputs directly and those must read 0 out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wen_q   <= 1'b0;
            f3_q    <= 3'b000;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                LSU_STATE_IDLE:
                    if (bus.io_req_valid) begin
                        addr_q  <= bus.io_req_addr;
                        wdata_q <= bus.io_req_wdata;
                        wen_q   <= bus.io_req_wen;
                        f3_q    <= bus.io_req_funct3;
                        cnt_q   <= '0;
                        rdata_q <= 32'h0;
                        fault_q <= req_illegal;
                        mis_q   <= !req_illegal && req_mis;
                    end
                LSU_STATE_REQ, LSU_STATE_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (rsp_hit)          rdata_q <= wen_q ? 32'h0 : load_data;
                    else if (timeout_hit) fault_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    lsu_align u_align (
        .wen        (wen_q),
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .store_data (wdata_q),
        .mem_rdata  (bus.io_mem_rdata),
        .mem_wdata  (bus.io_mem_wdata),
        .mem_wstrb  (bus.io_mem_wstrb),
        .load_data  (load_data)
    );

    assign bus.io_req_ready      = state_q == LSU_STATE_IDLE;
    assign bus.io_mem_valid      = state_q == LSU_STATE_REQ;
    assign bus.io_mem_addr       = {addr_q[31:2], 2'b00};
    assign bus.io_mem_wen        = wen_q;
    assign bus.io_resp_valid     = state_q == LSU_STATE_RESP;
    assign bus.io_resp_rdata     = rdata_q;
    assign bus.io_resp_misaligned = mis_q;
    assign bus.io_resp_fault     = fault_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected responses are queued when a request is
// driven and compared when the one-cycle response pulse appears.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if bus ();

    lsu #(.TIMEOUT_CYCLES(256), .CNT_W(9)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        got;
        logic [9:0]  lat;
        logic        bad;    // pulse longer than one cycle or overlapping req_ready
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] word;
    } stim_t;

    resp_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Memory responder knobs and observations.
    int          ready_delay  = 0;
    bit          respond_en   = 1'b1;
    bit          stray_rvalid = 1'b0;
    logic [31:0] mem_word     = 32'h0;
    int          vcnt         = 0;
    int          valid_cycles = 0;
    int          unstable     = 0;
    bit          acked        = 1'b0;
    logic [31:0] cap_addr     = 32'h0;
    logic [31:0] cap_wdata    = 32'h0;
    logic [3:0]  cap_wstrb    = 4'h0;
    logic        cap_wen      = 1'b0;

    always @(posedge clk) begin
        #2;
        bus.io_mem_ready  = 1'b0;
        bus.io_mem_rvalid = 1'b0;
        bus.io_mem_rdata  = 32'h0BAD_F00D;
        if (acked) begin
            acked = 1'b0;
            if (respond_en) begin
                bus.io_mem_rvalid = 1'b1;
                bus.io_mem_rdata  = mem_word;
            end
        end
        if (stray_rvalid) begin
            bus.io_mem_rvalid = 1'b1;
            bus.io_mem_rdata  = mem_word;
        end
        if (bus.io_mem_valid) begin
            if (vcnt == 0) begin
                cap_addr  = bus.io_mem_addr;
                cap_wdata = bus.io_mem_wdata;
                cap_wstrb = bus.io_mem_wstrb;
                cap_wen   = bus.io_mem_wen;
            end else if ({cap_addr, cap_wdata, cap_wstrb, cap_wen} !==
                         {bus.io_mem_addr, bus.io_mem_wdata, bus.io_mem_wstrb, bus.io_mem_wen}) begin
                unstable++;
            end
            vcnt++;
            valid_cycles++;
            if (vcnt > ready_delay) begin
                bus.io_mem_ready = 1'b1;
                acked = 1'b1;
            end
        end else begin
            vcnt = 0;
        end
    end

    function automatic stim_t mk(input logic [31:0] a, input logic [31:0] wd, input logic w,
                                 input logic [2:0] f3, input logic [31:0] word);
        stim_t s;
        s.addr = a; s.wd = wd; s.wen = w; s.f3 = f3; s.word = word;
        return s;
    endfunction

    function automatic resp_t exp_r(input int lat, input logic [31:0] d, input logic m, input logic f);
        resp_t e;
        e.got = 1'b1; e.lat = 10'(lat); e.bad = 1'b0; e.rdata = d; e.mis = m; e.fault = f;
        return e;
    endfunction

    // Reference behaviour, written from the access-size point of view.
    function automatic resp_t model(input stim_t s, input int dly);
        resp_t       e;
        int          size;
        logic        illegal;
        logic [31:0] sh;
        e = exp_r(3 + dly, 32'h0, 1'b0, 1'b0);
        size = 1 << s.f3[1:0];
        illegal = s.wen ? (s.f3 > 3'd2) : (s.f3 == 3'd3 || s.f3 > 3'd5);
        if (illegal) begin
            e.lat = 10'd1; e.fault = 1'b1;
        end else if ((s.addr[1:0] & 2'(size - 1)) != 2'b00) begin
            e.lat = 10'd1; e.mis = 1'b1;
        end else if (!s.wen) begin
            sh = s.word >> (8 * int'(s.addr[1:0]));
            case (s.f3)
                3'd0:    e.rdata = 32'($signed(sh[7:0]));
                3'd1:    e.rdata = 32'($signed(sh[15:0]));
                3'd4:    e.rdata = 32'(sh[7:0]);
                3'd5:    e.rdata = 32'(sh[15:0]);
                default: e.rdata = sh;
            endcase
        end
        return e;
    endfunction

    task automatic issue(input stim_t s);
        @(negedge clk);
        bus.io_req_valid  = 1'b1;
        bus.io_req_addr   = s.addr;
        bus.io_req_wdata  = s.wd;
        bus.io_req_wen    = s.wen;
        bus.io_req_funct3 = s.f3;
        mem_word          = s.word;
        @(negedge clk);
        bus.io_req_valid  = 1'b0;
    endtask

    // Called on the first negedge after acceptance; lat counts cycles from accept.
    task automatic wait_resp(input int budget, output resp_t r);
        r = '0;
        for (int k = 1; k <= budget; k++) begin
            if (bus.io_resp_valid) begin
                r.got   = 1'b1;
                r.lat   = 10'(k);
                r.bad   = bus.io_req_ready;
                r.rdata = bus.io_resp_rdata;
                r.mis   = bus.io_resp_misaligned;
                r.fault = bus.io_resp_fault;
                @(negedge clk);
                r.bad = r.bad | bus.io_resp_valid;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [105:0] obs;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            obs = {bus.io_req_ready, bus.io_mem_valid, bus.io_mem_wen, bus.io_mem_wstrb,
                   bus.io_resp_valid, bus.io_resp_misaligned, bus.io_resp_fault,
                   bus.io_mem_addr, bus.io_mem_wdata, bus.io_resp_rdata};
            n_vec++;
            if (obs !== {1'b1, 105'h0}) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: got %h expected %h", i, obs, {1'b1, 105'h0});
            end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    // Runs a list of transactions at a fixed ready delay; optionally checks the bus payload.
    task automatic run_list(input string nm, input stim_t st[$], input logic [68:0] bus_exp[$],
                            input int dly);
        resp_t r, e;
        ready_delay = dly;
        foreach (st[i]) begin
            sb.push_back(model(st[i], dly));
            issue(st[i]);
            wait_resp(600, r);
            e = sb.pop_front();
            n_vec++;
            if (r !== e) begin
                n_err++;
                $display("FAIL %s[%0d] resp: got v=%b lat=%0d bad=%b rdata=%h mis=%b flt=%b, expected v=%b lat=%0d bad=%b rdata=%h mis=%b flt=%b",
                         nm, i, r.got, r.lat, r.bad, r.rdata, r.mis, r.fault,
                         e.got, e.lat, e.bad, e.rdata, e.mis, e.fault);
            end
            if (i < bus_exp.size()) begin
                n_vec++;
                if ({cap_addr, cap_wdata, cap_wstrb, cap_wen} !== bus_exp[i]) begin
                    n_err++;
                    $display("FAIL %s[%0d] bus: got addr=%h wdata=%h wstrb=%b wen=%b, expected %h",
                             nm, i, cap_addr, cap_wdata, cap_wstrb, cap_wen, bus_exp[i]);
                end
            end
        end
        ready_delay = 0;
    endtask

    task automatic test_lw();
        stim_t st[$];
        logic [68:0] be[$];
        st.push_back(mk(32'h100, 32'h0, 1'b0, LSU_F3_LW, 32'hDEADBEEF));
        be.push_back({32'h100, 32'h0, 4'b0000, 1'b0});
        // Fixed-value cross-check of the model on the headline case.
        n_vec++;
        if (model(st[0], 0) !== exp_r(3, 32'hDEADBEEF, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL lw_model: got %h expected %h", model(st[0], 0), exp_r(3, 32'hDEADBEEF, 1'b0, 1'b0));
        end
        run_list("lw", st, be, 0);
    endtask

    task automatic test_loads();
        stim_t st[$];
        logic [68:0] be[$];
        resp_t e;
        st.push_back(mk(32'h103, 32'h0, 1'b0, LSU_F3_LB,  32'h80112233));
        st.push_back(mk(32'h103, 32'h0, 1'b0, LSU_F3_LBU, 32'h80112233));
        st.push_back(mk(32'h102, 32'h0, 1'b0, LSU_F3_LH,  32'h80112233));
        st.push_back(mk(32'h100, 32'h0, 1'b0, LSU_F3_LHU, 32'h80112233));
        st.push_back(mk(32'h101, 32'h0, 1'b0, LSU_F3_LB,  32'h80112233));
        st.push_back(mk(32'h102, 32'h0, 1'b0, LSU_F3_LHU, 32'h80112233));
        // Spot-check the model against hand-derived values from the plan.
        e = model(st[0], 0);
        n_vec++;
        if (e.rdata !== 32'hFFFFFF80 || model(st[1], 0).rdata !== 32'h00000080 ||
            model(st[2], 0).rdata !== 32'hFFFF8011) begin
            n_err++;
            $display("FAIL load_model: got %h %h %h expected ffffff80 00000080 ffff8011",
                     e.rdata, model(st[1], 0).rdata, model(st[2], 0).rdata);
        end
        run_list("loads", st, be, 0);
    endtask

    task automatic test_stores();
        stim_t st[$];
        logic [68:0] be[$];
        st.push_back(mk(32'h201, 32'h000000A5, 1'b1, LSU_F3_SB, 32'hFFFFFFFF));
        st.push_back(mk(32'h202, 32'h00001234, 1'b1, LSU_F3_SH, 32'hFFFFFFFF));
        st.push_back(mk(32'h204, 32'hCAFEF00D, 1'b1, LSU_F3_SW, 32'hFFFFFFFF));
        be.push_back({32'h200, 32'hA5A5A5A5, 4'b0010, 1'b1});
        be.push_back({32'h200, 32'h12341234, 4'b1100, 1'b1});
        be.push_back({32'h204, 32'hCAFEF00D, 4'b1111, 1'b1});
        run_list("stores", st, be, 0);
    endtask

    task automatic test_errors();
        stim_t st[$];
        logic [68:0] be[$];
        int v0 = valid_cycles;
        st.push_back(mk(32'h102, 32'h0, 1'b0, LSU_F3_LW, 32'h0));
        st.push_back(mk(32'h101, 32'h0, 1'b0, LSU_F3_LH, 32'h0));
        st.push_back(mk(32'h100, 32'h0, 1'b0, 3'b011,    32'h0));
        st.push_back(mk(32'h100, 32'h1, 1'b1, 3'b100,    32'h0));
        st.push_back(mk(32'h103, 32'h0, 1'b0, 3'b111,    32'h0));
        run_list("errors", st, be, 0);
        n_vec++;
        if (valid_cycles !== v0) begin
            n_err++;
            $display("FAIL errors_no_bus: got %0d mem_valid cycles, expected 0", valid_cycles - v0);
        end
    endtask

    task automatic test_backpressure();
        stim_t st[$];
        logic [68:0] be[$];
        int v0 = valid_cycles;
        int u0 = unstable;
        st.push_back(mk(32'h300, 32'h0,      1'b0, LSU_F3_LW, 32'h11223344));
        st.push_back(mk(32'h306, 32'h0000BEEF, 1'b1, LSU_F3_SH, 32'h0));
        be.push_back({32'h300, 32'h0,        4'b0000, 1'b0});
        be.push_back({32'h304, 32'hBEEFBEEF, 4'b1100, 1'b1});
        run_list("backpressure", st, be, 5);
        n_vec++;
        if (unstable !== u0 || valid_cycles - v0 !== 12) begin
            n_err++;
            $display("FAIL backpressure_hold: got %0d unstable, %0d valid cycles, expected 0 and 12",
                     unstable - u0, valid_cycles - v0);
        end
    endtask

    task automatic test_timeout();
        resp_t r, e;
        stim_t s;
        for (int i = 0; i < 3; i++) begin
            s = mk(32'h400 + 32'(4 * i), 32'h0, 1'b0, LSU_F3_LW, 32'h5A5A0001);
            case (i)
                0: begin respond_en = 1'b0; ready_delay = 0;    e = exp_r(257, 32'h0, 1'b0, 1'b1); end
                1: begin respond_en = 1'b1; ready_delay = 1000; e = exp_r(257, 32'h0, 1'b0, 1'b1); end
                default: begin respond_en = 1'b1; ready_delay = 254; e = exp_r(257, 32'h5A5A0001, 1'b0, 1'b0); end
            endcase
            sb.push_back(e);
            issue(s);
            wait_resp(600, r);
            e = sb.pop_front();
            n_vec++;
            if (r !== e) begin
                n_err++;
                $display("FAIL timeout[%0d]: got v=%b lat=%0d rdata=%h mis=%b flt=%b, expected v=%b lat=%0d rdata=%h mis=%b flt=%b",
                         i, r.got, r.lat, r.rdata, r.mis, r.fault, e.got, e.lat, e.rdata, e.mis, e.fault);
            end
        end
        respond_en = 1'b1;
        ready_delay = 0;
    endtask

    task automatic test_reset_in_wait();
        stim_t st[$];
        logic [68:0] be[$];
        logic [2:0] obs;
        logic seen = 1'b0;
        respond_en = 1'b0;
        issue(mk(32'h500, 32'h0, 1'b0, LSU_F3_LW, 32'h0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        respond_en = 1'b1;
        obs = {bus.io_req_ready, bus.io_resp_valid, bus.io_mem_valid};
        n_vec++;
        if (obs !== 3'b100) begin
            n_err++;
            $display("FAIL reset_in_wait: got ready/resp/mem_valid=%b expected 100", obs);
        end
        mem_word = 32'h12345678;
        stray_rvalid = 1'b1;
        @(negedge clk);
        stray_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen = seen | bus.io_resp_valid | !bus.io_req_ready;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL stray_rvalid: got activity=%b expected 0", seen);
        end
        st.push_back(mk(32'h504, 32'h0, 1'b0, LSU_F3_LW, 32'hA1B2C3D4));
        be.push_back({32'h504, 32'h0, 4'b0000, 1'b0});
        run_list("after_reset", st, be, 0);
    endtask

    task automatic test_random();
        stim_t st[$];
        logic [68:0] be[$];
        stim_t s;
        int dly, size;
        logic [31:0] wd_exp;
        logic [3:0]  ws_exp;
        for (int i = 0; i < 24; i++) begin
            s = mk(32'h800 + 32'($urandom_range(0, 63)), $urandom(), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), $urandom());
            if (i % 3 != 0) s.f3 = s.wen ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            if (i % 2 == 0) s.addr[1:0] = 2'b00;
            dly = $urandom_range(0, 3);
            size = 1 << s.f3[1:0];
            for (int b = 0; b < 4; b++) wd_exp[8*b +: 8] = s.wd[8*(b % size) +: 8];
            ws_exp = s.wen ? (4'((1 << size) - 1) << s.addr[1:0]) : 4'b0000;
            st.delete();
            be.delete();
            st.push_back(s);
            if (model(s, dly).lat != 10'd1)
                be.push_back({s.addr[31:2], 2'b00, s.wen ? wd_exp : s.wd, ws_exp, s.wen});
            run_list("random", st, be, dly);
        end
    endtask

    initial begin
        bus.io_req_valid  = 1'b0;
        bus.io_req_addr   = 32'h0;
        bus.io_req_wdata  = 32'h0;
        bus.io_req_wen    = 1'b0;
        bus.io_req_funct3 = 3'b000;

        test_reset();
        test_lw();
        test_loads();
        test_stores();
        test_errors();
        test_backpressure();
        test_timeout();
        test_reset_in_wait();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
